// File: rtl/ws2812_if.sv
//==============================================================================
// Module   : ws2812_if
// Purpose  : Frame/colour handshake between the colour source and the WS2812
//            serializer. The master side is the upstream colour source.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface ws2812_if #(
    parameter int IDX_W = 3
);
    logic             start;
    logic [7:0]       red_in;
    logic [7:0]       green_in;
    logic [7:0]       blue_in;
    logic             color_valid;
    logic             led_dout;
    logic             busy;
    logic             pixel_load;
    logic [IDX_W-1:0] pixel_index;
    logic             frame_done;

    modport master (
        output start, red_in, green_in, blue_in, color_valid,
        input  led_dout, busy, pixel_load, pixel_index, frame_done
    );

    modport slave (
        input  start, red_in, green_in, blue_in, color_valid,
        output led_dout, busy, pixel_load, pixel_index, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/ws2812_serializer.sv
//==============================================================================
// Module   : ws2812_serializer
// Purpose  : Serialises NUM_LEDS GRB pixels as WS2812 NRZ pulses, then holds
//            the line low for the latch interval. Optional macro
//            WS2812_GAMMA_EN squares each channel ((c*c)>>8) before loading.
// Revision : 1.0
//==============================================================================
`default_nettype none

module ws2812_serializer #(
    parameter int NUM_LEDS  = 8,
    parameter int IDX_W     = 3,
    parameter int T0H_CYC   = 4,
    parameter int T1H_CYC   = 9,
    parameter int BIT_CYC   = 15,
    parameter int RESET_CYC = 3600
) (
    input  logic    clk,
    input  logic    rst_n,
    ws2812_if.slave bus
);

    localparam int PH_W  = $clog2(BIT_CYC);
    localparam int LAT_W = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

    localparam logic [PH_W-1:0]  c_ph_last  = PH_W'(BIT_CYC - 1);
    localparam logic [PH_W-1:0]  c_ph_one   = PH_W'(1);
    localparam logic [PH_W-1:0]  c_t0h      = PH_W'(T0H_CYC);
    localparam logic [PH_W-1:0]  c_t1h      = PH_W'(T1H_CYC);
    localparam logic [LAT_W-1:0] c_lat_last = LAT_W'(RESET_CYC - 1);
    localparam logic [LAT_W-1:0] c_lat_one  = LAT_W'(1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_LEDS - 1);
    localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);
    localparam logic [4:0]       c_bit_last = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [4:0]       bit_q, bit_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [23:0]      shift_q, shift_d;
    logic             led_q, led_d;

    logic             w_load;
    logic             w_reload;
    logic             w_done;
    logic [23:0]      w_load_word;

    function automatic logic [7:0] gamma8(input logic [7:0] c);
`ifdef WS2812_GAMMA_EN
        logic [15:0] sq;
        sq = {8'h00, c} * {8'h00, c};
        return sq[15:8];
`else
        return c;
`endif
    endfunction

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        idx_d    = idx_q;
        lat_d    = lat_q;
        shift_d  = shift_q;
        w_load   = 1'b0;
        w_reload = 1'b0;
        w_done   = 1'b0;
        w_load_word = bus.color_valid ?
            {gamma8(bus.green_in), gamma8(bus.red_in), gamma8(bus.blue_in)} : 24'h000000;

        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (bus.start) begin
                    state_d = ST_LOAD;
                    phase_d = '0;
                    bit_d   = '0;
                end
            end
            ST_LOAD: begin
                w_load  = 1'b1;
                shift_d = w_load_word;
                phase_d = '0;
                bit_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (phase_q == c_ph_last) begin
                    phase_d = '0;
                    if (bit_q == c_bit_last) begin
                        bit_d = '0;
                        if (idx_q == c_idx_last) begin
                            state_d = ST_LATCH;
                            lat_d   = '0;
                        end else begin
                            // Reload in the last cycle of bit 23 so the next pixel follows gap-free
                            w_reload = 1'b1;
                            idx_d    = idx_q + c_idx_one;
                            shift_d  = w_load_word;
                        end
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        shift_d = {shift_q[22:0], 1'b0};
                    end
                end else begin
                    phase_d = phase_q + c_ph_one;
                end
            end
            ST_LATCH: begin
                if (lat_q == c_lat_last) begin
                    w_done  = 1'b1;
                    state_d = ST_IDLE;
                    lat_d   = '0;
                    idx_d   = '0;
                end else begin
                    lat_d = lat_q + c_lat_one;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered output: computed from the next-cycle phase and bit value
        led_d = (state_d == ST_SEND) && (phase_d < (shift_d[23] ? c_t1h : c_t0h));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            lat_q   <= '0;
            shift_q <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            shift_q <= shift_d;
            led_q   <= led_d;
        end
    end

    assign bus.led_dout    = led_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.pixel_load  = w_load | w_reload;
    assign bus.pixel_index = w_reload ? (idx_q + c_idx_one) : idx_q;
    assign bus.frame_done  = w_done;

endmodule

`default_nettype wire

// File: tb/tb_ws2812_serializer.sv
//==============================================================================
// Module   : tb_ws2812_serializer
// Purpose  : Self-checking bench: table of per-pixel colours with expected
//            words, waveform decoder feeding a scoreboard, plus corner sequences.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_ws2812_serializer;

    localparam int N        = 3;
    localparam int BIT      = 15;
    localparam int RST_CYC  = 3600;
    localparam int PIX_CYC  = 24 * BIT;
    localparam int DONE_OFF = N * PIX_CYC + RST_CYC;

    typedef struct {
        logic [7:0]  g;
        logic [7:0]  r;
        logic [7:0]  b;
        logic        v;
        logic [23:0] exp_plain;
        logic [23:0] exp_gamma;
    } vec_t;

    vec_t vec [9];

    logic clk;
    logic rst_n;
    int   fbase;
    int   cyc;
    int   n_pass;
    int   n_checks;

    ws2812_if #(.IDX_W(2)) bus ();

    ws2812_serializer #(
        .NUM_LEDS (N),
        .IDX_W    (2),
        .T0H_CYC  (4),
        .T1H_CYC  (9),
        .BIT_CYC  (BIT),
        .RESET_CYC(RST_CYC)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Upstream colour source: looks up the current frame's table by pixel_index
    always_comb begin
        bus.green_in    = vec[fbase + int'(bus.pixel_index)].g;
        bus.red_in      = vec[fbase + int'(bus.pixel_index)].r;
        bus.blue_in     = vec[fbase + int'(bus.pixel_index)].b;
        bus.color_valid = vec[fbase + int'(bus.pixel_index)].v;
    end

    function automatic logic [23:0] exp_of(input int i);
`ifdef WS2812_GAMMA_EN
        return vec[i].exp_gamma;
`else
        return vec[i].exp_plain;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    logic [23:0] exp_q [$];
    int          load_cyc;
    int          nloads;
    int          nbits_pix;
    int          nbits_frame;
    int          latch_hi;
    int          pos;
    int          hi;
    logic        dec_on;
    logic        shape_ok;
    logic [23:0] word;

    task automatic monitor_step();
        int off;
        if (!rst_n) begin
            dec_on      = 1'b0;
            nloads      = 0;
            nbits_pix   = 0;
            nbits_frame = 0;
            latch_hi    = 0;
            exp_q.delete();
            return;
        end
        off = cyc - load_cyc;

        if (bus.pixel_load) begin
            if (nloads == 0) load_cyc = cyc;
            else check("load_offset", off, nloads * PIX_CYC);
            check("load_index", bus.pixel_index, nloads);
            if (nloads < N) exp_q.push_back(exp_of(fbase + nloads));
            nloads++;
        end

        if (!dec_on && nloads > 0 && nbits_frame < N * 24 && bus.led_dout) begin
            dec_on    = 1'b1;
            pos       = 0;
            nbits_pix = 0;
            shape_ok  = 1'b1;
            word      = '0;
            if (nbits_frame == 0) check("first_high_latency", off, 1);
        end

        if (dec_on) begin
            // Each bit window must open high and be one contiguous high run
            if (pos == 0) begin
                hi = 0;
                if (!bus.led_dout) shape_ok = 1'b0;
            end
            if (bus.led_dout) begin
                if (hi != pos) shape_ok = 1'b0;
                hi++;
            end
            pos++;
            if (pos == BIT) begin
                if (hi != 4 && hi != 9) shape_ok = 1'b0;
                word = {word[22:0], (hi == 9)};
                pos  = 0;
                nbits_pix++;
                if (nbits_pix == 24) begin
                    if (exp_q.size() == 0) check("pixel_word_unexpected", word, 32'hFFFF_FFFF);
                    else check("pixel_word", word, exp_q.pop_front());
                    check("pixel_shape", shape_ok, 1);
                    nbits_frame += 24;
                    nbits_pix   = 0;
                    shape_ok    = 1'b1;
                    if (nbits_frame >= N * 24) dec_on = 1'b0;
                end
            end
        end else if (nbits_frame == N * 24 && bus.led_dout) begin
            latch_hi++;
        end

        if (bus.frame_done) begin
            check("frame_done_offset", off, DONE_OFF);
            check("frame_bits", nbits_frame, N * 24);
            check("latch_low", latch_hi, 0);
            check("frame_done_busy", bus.busy, 1);
            nloads      = 0;
            nbits_frame = 0;
            latch_hi    = 0;
            dec_on      = 1'b0;
            exp_q.delete();
        end
    endtask

    initial begin
        dec_on      = 1'b0;
        nloads      = 0;
        nbits_pix   = 0;
        nbits_frame = 0;
        latch_hi    = 0;
        load_cyc    = 0;
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    task automatic wait_frame_done();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.frame_done && k < DONE_OFF + 200);
        check("frame_done_seen", bus.frame_done, 1);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        //          g      r      b      v     plain       gamma
        vec[0] = '{8'h80, 8'h00, 8'hFF, 1'b1, 24'h8000FF, 24'h4000FE};
        vec[1] = '{8'hAA, 8'h55, 8'h0F, 1'b0, 24'h000000, 24'h000000};
        vec[2] = '{8'hFF, 8'h80, 8'h10, 1'b1, 24'hFF8010, 24'hFE4001};
        vec[3] = '{8'h12, 8'h34, 8'h56, 1'b1, 24'h123456, 24'h010A1C};
        vec[4] = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 24'hFFFFFF, 24'hFEFEFE};
        vec[5] = '{8'h00, 8'h00, 8'h01, 1'b1, 24'h000001, 24'h000000};
        vec[6] = '{8'h5A, 8'hC3, 8'h96, 1'b1, 24'h5AC396, 24'h1F9457};
        vec[7] = '{8'h01, 8'h02, 8'h03, 1'b1, 24'h010203, 24'h000000};
        vec[8] = '{8'h01, 8'h02, 8'h03, 1'b1, 24'h010203, 24'h000000};

        n_pass    = 0;
        n_checks  = 0;
        fbase     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_led_dout",    bus.led_dout, 0);
        check("rst_busy",        bus.busy, 0);
        check("rst_pixel_load",  bus.pixel_load, 0);
        check("rst_pixel_index", bus.pixel_index, 0);
        check("rst_frame_done",  bus.frame_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", bus.busy, 0);

        // Frame 1: a start while busy and a start coincident with frame_done are both ignored
        pulse_start();
        check("load_strobe_f1", {bus.busy, bus.pixel_load, bus.pixel_index}, 4'b1100);
        repeat (200) @(negedge clk);
        pulse_start();
        check("start_while_busy", {bus.busy, bus.pixel_load}, 2'b10);
        wait_frame_done();
        pulse_start();
        check("busy_falls_after_done", {bus.busy, bus.pixel_load}, 2'b00);
        repeat (4) @(negedge clk);
        check("coincident_start_ignored", bus.busy, 0);

        // Frame 2 ends with a restart in the cycle right after frame_done
        fbase = 3;
        pulse_start();
        check("load_strobe_f2", {bus.busy, bus.pixel_load, bus.pixel_index}, 4'b1100);
        wait_frame_done();
        fbase = 6;
        @(negedge clk);
        bus.start = 1'b1;
        check("idle_after_done_f2", bus.busy, 0);
        @(negedge clk);
        bus.start = 1'b0;
        check("restart_after_done", {bus.busy, bus.pixel_load, bus.pixel_index}, 4'b1100);

        // Frame 3 is cut by an asynchronous reset while pixel 1 drives high
        begin
            int k;
            k = 0;
            while (!(bus.pixel_index == 2'd1 && bus.led_dout) && k < 2 * PIX_CYC) begin
                @(negedge clk);
                k++;
            end
        end
        check("reset_point_reached", {bus.pixel_index, bus.led_dout}, 3'b011);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led_dout",    bus.led_dout, 0);
        check("async_rst_busy",        bus.busy, 0);
        check("async_rst_pixel_load",  bus.pixel_load, 0);
        check("async_rst_pixel_index", bus.pixel_index, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", {bus.busy, bus.pixel_load, bus.led_dout}, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
